// File: rtl/vehicle_ctrl_pkg.sv
// vehicle_ctrl_pkg
//   Shared types for the vehicle drive controller: gear state, gear command
//   and turn state encodings, plus the raw turn-request codes carried on
//   _turnShift.
package vehicle_ctrl_pkg;

  typedef enum logic [2:0] {
    GEAR_LOCK    = 3'b000,
    GEAR_PARK    = 3'b001,
    GEAR_REVERSE = 3'b010,
    GEAR_NEUTRAL = 3'b011,
    GEAR_FORWARD = 3'b100
  } gear_state_t;

  typedef enum logic [2:0] {
    CMD_HOLD    = 3'b000,
    CMD_PARK    = 3'b001,
    CMD_REVERSE = 3'b010,
    CMD_NEUTRAL = 3'b011,
    CMD_DRIVE   = 3'b100,
    CMD_UP      = 3'b101,
    CMD_DOWN    = 3'b110,
    CMD_RSVD    = 3'b111
  } gear_cmd_t;

  typedef enum logic [1:0] {
    TURN_NONE   = 2'b00,
    TURN_LEFT   = 2'b01,
    TURN_HAZARD = 2'b10,
    TURN_RIGHT  = 2'b11
  } turn_state_t;

  localparam logic [1:0] TREQ_NONE   = 2'b00;
  localparam logic [1:0] TREQ_LEFT   = 2'b01;
  localparam logic [1:0] TREQ_RIGHT  = 2'b10;
  localparam logic [1:0] TREQ_HAZARD = 2'b11;

endpackage

// File: rtl/vehicle_drive_ctrl_blink_timer.sv
// blink_timer
//   Half-period counter and blink phase flop for the turn lamps.
//   Ports:
//     clock    - system clock
//     _reset   - synchronous active-high reset (count 0, phase 0)
//     restart  - force count 0, phase 1 on this edge
//     phase    - blink phase: HALF_PERIOD cycles high, HALF_PERIOD low
module blink_timer #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clock,
  input  logic _reset,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (_reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/vehicle_drive_ctrl.sv
// vehicle_drive_ctrl
//   Gear selector and turn-signal controller. Edge-detects gear and turn
//   commands, tracks gear state (with numbered forward gear) and turn state,
//   and drives blinking lamp outputs.
//   Optional feature macro: HAZARD_EN (enables _turnShift = 11 hazard toggle).
//   Ports:
//     clock       - system clock
//     _reset      - synchronous active-high reset
//     _switch     - ignition (1 = on)
//     _brake      - brake interlock
//     _gearCmd    - gear command (HOLD/PARK/REVERSE/NEUTRAL/DRIVE/UP/DOWN)
//     _turnShift  - turn request (none/left/right/hazard)
//     _gearState  - current gear state
//     _fwdGear    - current forward gear, 0 outside FORWARD
//     _turnState  - current turn state
//     _leftLamp, _rightLamp - lamp drives
module vehicle_drive_ctrl
  import vehicle_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FWD_GEARS     = 5,
  parameter int unsigned BLINK_HALF_PERIOD = 4
) (
  input  logic                                 clock,
  input  logic                                 _reset,
  input  logic                                 _switch,
  input  logic                                 _brake,
  input  logic [2:0]                           _gearCmd,
  input  logic [1:0]                           _turnShift,
  output logic [2:0]                           _gearState,
  output logic [$clog2(NUM_FWD_GEARS+1)-1:0]   _fwdGear,
  output logic [1:0]                           _turnState,
  output logic                                 _leftLamp,
  output logic                                 _rightLamp
);

  localparam int unsigned GW = $clog2(NUM_FWD_GEARS + 1);
  localparam logic [GW-1:0] MAX_GEAR = GW'(NUM_FWD_GEARS);
  localparam logic [GW-1:0] FIRST_GEAR = GW'(1);

  gear_state_t gearState, gearNext;
  turn_state_t turnState, turnNext;
  gear_cmd_t   gearCmd;
  logic [GW-1:0] fwdGear, fwdNext;
  logic [2:0]  prevGearCmd;
  logic [1:0]  prevTurnShift;
  logic        gearEv, turnEv;
  logic        phase;

  assign gearCmd = gear_cmd_t'(_gearCmd);
  assign gearEv  = (_gearCmd != 3'b000) && (_gearCmd != prevGearCmd);
  assign turnEv  = (_turnShift != 2'b00) && (_turnShift != prevTurnShift);

  // Gear FSM next state
  always_comb begin
    gearNext = gearState;
    fwdNext  = fwdGear;
    if (!_switch) begin
      gearNext = GEAR_LOCK;
    end else begin
      case (gearState)
        GEAR_LOCK: gearNext = GEAR_PARK;
        GEAR_PARK: begin
          // Leaving PARK in any direction needs the brake held.
          if (gearEv && _brake) begin
            case (gearCmd)
              CMD_REVERSE: gearNext = GEAR_REVERSE;
              CMD_NEUTRAL: gearNext = GEAR_NEUTRAL;
              CMD_DRIVE: begin
                gearNext = GEAR_FORWARD;
                fwdNext  = FIRST_GEAR;
              end
              default: ;
            endcase
          end
        end
        GEAR_REVERSE: begin
          if (gearEv) begin
            case (gearCmd)
              CMD_PARK:    gearNext = GEAR_PARK;
              CMD_NEUTRAL: gearNext = GEAR_NEUTRAL;
              CMD_DRIVE: begin
                if (_brake) begin
                  gearNext = GEAR_FORWARD;
                  fwdNext  = FIRST_GEAR;
                end
              end
              default: ;
            endcase
          end
        end
        GEAR_NEUTRAL: begin
          if (gearEv) begin
            case (gearCmd)
              CMD_PARK:    gearNext = GEAR_PARK;
              CMD_REVERSE: gearNext = GEAR_REVERSE;
              CMD_DRIVE, CMD_UP: begin
                gearNext = GEAR_FORWARD;
                fwdNext  = FIRST_GEAR;
              end
              default: ;
            endcase
          end
        end
        GEAR_FORWARD: begin
          if (gearEv) begin
            case (gearCmd)
              CMD_PARK:    gearNext = GEAR_PARK;
              CMD_NEUTRAL: gearNext = GEAR_NEUTRAL;
              CMD_REVERSE: if (_brake) gearNext = GEAR_REVERSE;
              CMD_UP:      if (fwdGear < MAX_GEAR) fwdNext = fwdGear + GW'(1);
              CMD_DOWN:    if (fwdGear > FIRST_GEAR) fwdNext = fwdGear - GW'(1);
              default: ;
            endcase
          end
        end
        default: gearNext = GEAR_LOCK;
      endcase
    end
    if (gearNext != GEAR_FORWARD) fwdNext = '0;
  end

  // Turn FSM next state
  always_comb begin
    turnNext = turnState;
    if (!_switch) begin
      turnNext = TURN_NONE;
    end else if (turnEv) begin
      case (_turnShift)
        TREQ_LEFT: begin
          case (turnState)
            TURN_NONE:  turnNext = TURN_LEFT;
            TURN_LEFT:  turnNext = TURN_NONE;
            TURN_RIGHT: turnNext = TURN_NONE;
            default: ;
          endcase
        end
        TREQ_RIGHT: begin
          case (turnState)
            TURN_NONE:  turnNext = TURN_RIGHT;
            TURN_RIGHT: turnNext = TURN_NONE;
            TURN_LEFT:  turnNext = TURN_NONE;
            default: ;
          endcase
        end
`ifdef HAZARD_EN
        TREQ_HAZARD: turnNext = (turnState == TURN_HAZARD) ? TURN_NONE : TURN_HAZARD;
`else
        TREQ_HAZARD: turnNext = turnState;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (_reset) begin
      gearState     <= GEAR_LOCK;
      fwdGear       <= '0;
      turnState     <= TURN_NONE;
      prevGearCmd   <= '0;
      prevTurnShift <= '0;
    end else begin
      gearState     <= gearNext;
      fwdGear       <= fwdNext;
      turnState     <= turnNext;
      prevGearCmd   <= _gearCmd;
      prevTurnShift <= _turnShift;
    end
  end

  // Restart aligns the lamp's first high phase with the edge the turn state changes.
  blink_timer #(
    .HALF_PERIOD(BLINK_HALF_PERIOD)
  ) uBlink (
    .clock  (clock),
    ._reset (_reset),
    .restart(turnNext != turnState),
    .phase  (phase)
  );

  always_comb begin
`ifdef HAZARD_EN
    _leftLamp  = phase & ((turnState == TURN_LEFT)  | (turnState == TURN_HAZARD));
    _rightLamp = phase & ((turnState == TURN_RIGHT) | (turnState == TURN_HAZARD));
`else
    _leftLamp  = phase & (turnState == TURN_LEFT);
    _rightLamp = phase & (turnState == TURN_RIGHT);
`endif
  end

  assign _gearState = gearState;
  assign _fwdGear   = fwdGear;
  assign _turnState = turnState;

endmodule

// File: tb/tb_vehicle_drive_ctrl.sv
module tb_vehicle_drive_ctrl;

  localparam int N = 5;
  localparam int H = 4;

  logic clock = 1'b0;
  logic _reset, _switch, _brake;
  logic [2:0] _gearCmd;
  logic [1:0] _turnShift;
  logic [2:0] _gearState;
  logic [$clog2(N+1)-1:0] _fwdGear;
  logic [1:0] _turnState;
  logic _leftLamp, _rightLamp;

  int nChecks = 0;
  int nPass = 0;
  bit chkEn = 0;

  vehicle_drive_ctrl #(.NUM_FWD_GEARS(N), .BLINK_HALF_PERIOD(H)) dut (
    .clock(clock), ._reset(_reset), ._switch(_switch), ._brake(_brake),
    ._gearCmd(_gearCmd), ._turnShift(_turnShift), ._gearState(_gearState),
    ._fwdGear(_fwdGear), ._turnState(_turnState), ._leftLamp(_leftLamp),
    ._rightLamp(_rightLamp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input int exp);
    nChecks++;
    if (act !== exp[7:0]) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else nPass++;
  endtask

  // Reference model: gear 0 LOCK,1 PARK,2 REV,3 NEU,4 FWD; turn 0 none,1 left,3 right,2 hazard.
  int mGear = 0, mFwd = 0, mTurn = 0, mPrevG = 0, mPrevT = 0, mAge = 0;

  always @(posedge clock) begin : model
    int g, f, t;
    bit gEv, tEv;
    if (_reset) begin
      mGear = 0; mFwd = 0; mTurn = 0; mPrevG = 0; mPrevT = 0; mAge = 0;
      chkEn = 1;
    end else begin
      gEv = (_gearCmd != 0) && (int'(_gearCmd) != mPrevG);
      tEv = (_turnShift != 0) && (int'(_turnShift) != mPrevT);
      g = mGear; f = mFwd; t = mTurn;
      if (!_switch) begin
        g = 0; t = 0;
      end else begin
        if (mGear == 0) g = 1;
        else if (gEv && !(mGear == 1 && !_brake)) begin
          case (_gearCmd)
            3'd1: g = 1;
            3'd3: g = 3;
            3'd2: if (mGear != 4 || _brake) g = 2;
            3'd4: if (mGear != 4 && (mGear != 2 || _brake)) begin g = 4; f = 1; end
            3'd5: begin
              if (mGear == 4) f = (f < N) ? f + 1 : N;
              else if (mGear == 3) begin g = 4; f = 1; end
            end
            3'd6: if (mGear == 4 && f > 1) f = f - 1;
            default: ;
          endcase
        end
        if (tEv) begin
          if (_turnShift == 2'd1 && t != 2) t = (t == 0) ? 1 : 0;
          else if (_turnShift == 2'd2 && t != 2) t = (t == 0) ? 3 : 0;
`ifdef HAZARD_EN
          else if (_turnShift == 2'd3) t = (t == 2) ? 0 : 2;
`endif
        end
      end
      if (g != 4) f = 0;
      mAge = (t != mTurn) ? 0 : mAge + 1;
      mGear = g; mFwd = f; mTurn = t;
      mPrevG = int'(_gearCmd); mPrevT = int'(_turnShift);
    end
  end

  always @(negedge clock) begin : compare
    bit ph;
    if (chkEn) begin
      ph = ((mAge / H) % 2) == 0;
      chk("gearState", _gearState, mGear);
      chk("fwdGear", _fwdGear, mFwd);
      chk("turnState", _turnState, mTurn);
      chk("leftLamp", _leftLamp, int'(ph && (mTurn == 1 || mTurn == 2)));
      chk("rightLamp", _rightLamp, int'(ph && (mTurn == 3 || mTurn == 2)));
    end
  end

  task automatic drive(input logic [2:0] g, input logic [1:0] t, input logic b);
    @(negedge clock);
    _gearCmd = g; _turnShift = t; _brake = b;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int upExp[6];
    int dnExp[6];
    int lampSeq[9];
    upExp = '{2, 3, 4, 5, 5, 5};
    dnExp = '{4, 3, 2, 1, 1, 1};
    lampSeq = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

    _reset = 1; _switch = 1; _brake = 0; _gearCmd = 0; _turnShift = 0;
    repeat (3) drive(3'd0, 2'd0, 1'b0);
    chk("rst_gear", _gearState, 0);
    chk("rst_fwd", _fwdGear, 0);
    chk("rst_turn", _turnState, 0);
    chk("rst_lamps", {_leftLamp, _rightLamp}, 0);

    _reset = 0;
    drive(3'd0, 2'd0, 1'b0);
    chk("lock_to_park", _gearState, 1);

    drive(3'd4, 2'd0, 1'b0);
    chk("park_drive_nobrake", _gearState, 1);
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd4, 2'd0, 1'b1);
    chk("park_drive_brake", _gearState, 4);
    chk("park_drive_gear1", _fwdGear, 1);

    for (int i = 0; i < 6; i++) begin
      drive(3'd0, 2'd0, 1'b0);
      drive(3'd5, 2'd0, 1'b0);
      chk("up_pulse", _fwdGear, upExp[i]);
    end
    for (int i = 0; i < 6; i++) begin
      drive(3'd0, 2'd0, 1'b0);
      drive(3'd6, 2'd0, 1'b0);
      chk("down_pulse", _fwdGear, dnExp[i]);
    end
    drive(3'd0, 2'd0, 1'b0);
    repeat (10) drive(3'd5, 2'd0, 1'b0);
    chk("up_held_once", _fwdGear, 2);
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd4, 2'd0, 1'b0);
    chk("drive_holds_gear", _fwdGear, 2);

    drive(3'd2, 2'd0, 1'b0);
    chk("fwd_rev_nobrake", _gearState, 4);
    drive(3'd3, 2'd0, 1'b0);
    chk("to_neutral", _gearState, 3);
    chk("neutral_fwd0", _fwdGear, 0);
    drive(3'd2, 2'd0, 1'b0);
    chk("neutral_to_rev", _gearState, 2);

    drive(3'd0, 2'd1, 1'b0);
    chk("left_req", _turnState, 1);
    chk("left_lamp0", _leftLamp, lampSeq[0]);
    for (int k = 1; k < 9; k++) begin
      drive(3'd0, 2'd1, 1'b0);
      chk("left_blink", _leftLamp, lampSeq[k]);
      chk("right_off", _rightLamp, 0);
    end
    drive(3'd0, 2'd2, 1'b0);
    chk("right_cancels", _turnState, 0);
    chk("cancel_lamps", {_leftLamp, _rightLamp}, 0);
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd0, 2'd2, 1'b0);
    chk("right_req", _turnState, 3);
    chk("right_lamp", _rightLamp, 1);

    _switch = 0;
    drive(3'd0, 2'd0, 1'b0);
    chk("off_gear", _gearState, 0);
    chk("off_fwd", _fwdGear, 0);
    chk("off_turn", _turnState, 0);
    chk("off_lamps", {_leftLamp, _rightLamp}, 0);
    _switch = 1;
    drive(3'd0, 2'd0, 1'b0);
    chk("on_park", _gearState, 1);
    drive(3'd0, 2'd2, 1'b0);
    chk("right_again", _turnState, 3);

    drive(3'd0, 2'd3, 1'b0);
`ifdef HAZARD_EN
    chk("hazard_on", _turnState, 2);
    chk("hazard_lamps", {_leftLamp, _rightLamp}, 3);
`else
    chk("hazard_ignored", _turnState, 3);
`endif
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd0, 2'd3, 1'b0);
`ifdef HAZARD_EN
    chk("hazard_off", _turnState, 0);
`else
    chk("hazard_ignored2", _turnState, 3);
`endif

    drive(3'd0, 2'd0, 1'b1);
    drive(3'd4, 2'd0, 1'b1);
    drive(3'd0, 2'd0, 1'b1);
    drive(3'd5, 2'd0, 1'b1);
    drive(3'd0, 2'd0, 1'b1);
    drive(3'd2, 2'd0, 1'b1);
    chk("fwd_rev_brake", _gearState, 2);
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd1, 2'd0, 1'b0);
    chk("to_park", _gearState, 1);

    _reset = 1;
    drive(3'd0, 2'd1, 1'b0);
    chk("midrst_gear", _gearState, 0);
    chk("midrst_turn", _turnState, 0);
    _reset = 0;
    drive(3'd0, 2'd1, 1'b0);
    chk("post_rst_park", _gearState, 1);
    chk("held_through_rst", _turnState, 1);
    chk("held_lamp", _leftLamp, 1);
    repeat (3) drive(3'd0, 2'd0, 1'b0);

    chkEn = 0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/vehicle_drive_ctrl.md
# vehicle_drive_ctrl

Parametrised gear-selector and turn-signal controller for the vehicle control path. It takes the ignition switch, edge-detected gear and turn commands and a brake interlock input. It tracks gear state, including a numbered forward gear 1..NUM_FWD_GEARS, and turn state. It also drives blinking left/right lamp outputs from an internal half-period timer. It sits between the driver-input decode and the lamp/transmission actuator logic.

## Interface
- NUM_FWD_GEARS, 5, number of forward gears; legal 1..15
- BLINK_HALF_PERIOD, 4, lamp on-time and off-time in clock cycles; legal ≥1
- clock  in  1  system clock; all state updates on rising edge
- _reset  in  1  synchronous, active-high reset
- _switch  in  1  ignition; 0 = off, 1 = on
- _brake  in  1  brake pedal held; interlock for leaving PARK and for REVERSE↔FORWARD
- _gearCmd  in  3  000 HOLD, 001 PARK, 010 REVERSE, 011 NEUTRAL, 100 DRIVE, 101 UP, 110 DOWN, 111 ignored
- _turnShift  in  2  00 none, 01 left, 10 right, 11 hazard
- _gearState  out  3  000 LOCK, 001 PARK, 010 REVERSE, 011 NEUTRAL, 100 FORWARD
- _fwdGear  out  $clog2(NUM_FWD_GEARS+1)  current forward gear; 0 unless _gearState = FORWARD
- _turnState  out  2  00 NONE, 01 LEFT, 11 RIGHT, 10 HAZARD
- _leftLamp, _rightLamp  out  1 each  lamp drive

## Operation
- Commands are edge-triggered: a command acts only in a cycle where it is nonzero and differs from the value registered on the previous edge. A held value acts once.
- Ignition off (_switch = 0) has priority over all commands. Next state is LOCK, _fwdGear 0, _turnState NONE, lamps 0.
- Gear FSM transitions (states other than LOCK assume _switch = 1):
  - LOCK → PARK unconditionally.
  - PARK → REVERSE/NEUTRAL/FORWARD(gear 1) on the matching command only if _brake = 1; otherwise it stays in PARK.
  - Any on-state → PARK on PARK. Any on-state → NEUTRAL on NEUTRAL.
  - NEUTRAL → REVERSE on REVERSE. NEUTRAL → FORWARD(gear 1) on DRIVE or UP.
  - REVERSE ↔ FORWARD directly requires _brake = 1; otherwise the state is held. Entering FORWARD always sets gear 1.
- Forward gear changes:
  - UP increments _fwdGear, saturating at NUM_FWD_GEARS.
  - DOWN decrements _fwdGear, saturating at 1.
  - UP/DOWN are ignored outside FORWARD, except UP in NEUTRAL as above.
  - DRIVE while in FORWARD holds the current gear.
- Turn FSM (allowed in any on-state):
  - Left request: NONE→LEFT, LEFT→NONE, RIGHT→NONE (opposite request cancels).
  - Right request is symmetric.
  - Requests are ignored while in HAZARD.
- Lamps:
  - Blink phase is 1 for BLINK_HALF_PERIOD cycles, then 0 for BLINK_HALF_PERIOD cycles, repeating.
  - _leftLamp = phase & (LEFT | HAZARD); _rightLamp = phase & (RIGHT | HAZARD).
  - On any _turnState change, the counter restarts and phase = 1.
  - On a change to NONE, the lamps are 0.
- Simultaneous events: ignition-off beats commands, and gear and turn commands in the same cycle both act.

## Timing
- Reset: _gearState LOCK, _fwdGear 0, _turnState NONE, both lamps 0, blink counter 0, phase 0, previous-command registers 0. Reset beats _switch.
- Reset mid-operation returns all outputs to the reset values on the next edge. A command held through reset release acts on the first edge after release, because its previous value is 0.
- All outputs are registered with 1-cycle latency: a command present before edge N is reflected in the outputs after edge N.
- Lamp goes high on the same edge that _turnState becomes active. The first transition to 0 occurs BLINK_HALF_PERIOD edges later.
- The blink counter wraps at BLINK_HALF_PERIOD-1 and toggles phase at the wrap. With BLINK_HALF_PERIOD = 1 the phase toggles every cycle.

## Configuration
- HAZARD_EN defined: _turnShift = 11 toggles HAZARD on/off from any turn state. Entering HAZARD discards a pending LEFT/RIGHT, and leaving HAZARD returns to NONE.
- HAZARD_EN undefined: _turnShift = 11 is ignored, _turnState never equals 10, and no hazard logic is synthesised.

## Structure
- The vehicle_ctrl_pkg package holds:
  - enums gear_state_t, gear_cmd_t, turn_state_t, with the encodings above;
  - turn request constants.
- Sub-module blink_timer (parameter HALF_PERIOD; ports clock, _reset, restart, phase) contains the counter and phase flop.

## Test plan
- Reset with _switch = 1: during reset, outputs LOCK/0/NONE/0/0. After release, PARK after 1 edge.
- PARK, DRIVE with _brake = 0 → stays PARK. Re-issue DRIVE (HOLD then DRIVE) with _brake = 1 → FORWARD, _fwdGear = 1.
- NUM_FWD_GEARS = 5: six UP pulses from gear 1 → 2,3,4,5,5,5. Six DOWN pulses → 4,3,2,1,1,1. Holding UP for 10 cycles → one increment only.
- FORWARD, REVERSE with _brake = 0 → held. NEUTRAL then REVERSE → REVERSE. _switch = 0 with a turn active → LOCK, _fwdGear 0, NONE, lamps 0 next edge.
- BLINK_HALF_PERIOD = 4: left request → LEFT; _leftLamp 1,1,1,1,0,0,0,0,1 and _rightLamp stays 0. Right request → NONE, lamps 0. Second right request → RIGHT.
- With HAZARD_EN: from RIGHT, request 11 → HAZARD, both lamps in phase. Request 11 again → NONE. Without HAZARD_EN, the same stimulus leaves RIGHT unchanged.
